frame_stack_ctrl: RTL
=====================

Name: frame_stack_ctrl

Overview:
Frame stack controller for the recursive Fibonacci datapath. It services push/pop requests from the recursion controller and stores frames {res, flag, n} in an internal synchronous-read RAM. Completion of every request is signalled by a one-cycle readySig pulse. It also reports stack occupancy, empty/full state and sticky overflow/underflow errors.

Parameters:
DW, 8, width of each frame field (n, flag, res)
DEPTH, 16, number of frame slots; power of two, at least 2
AW, 4, stack-pointer/address width; equals log2(DEPTH)

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
pushSig  in  1  push request; level, held by requester until readySig
popSig  in  1  pop request; level, held by requester until readySig
n_in  in  DW  frame n field to push
flag_in  in  DW  frame flag field to push
res_in  in  DW  frame res field to push
readySig  out  1  one-cycle completion pulse for the current request
n_out  out  DW  popped n field; registered, holds value until the next successful pop
flag_out  out  DW  popped flag field; registered
res_out  out  DW  popped res field; registered
pop_empty  out  1  high together with readySig when a pop found the stack empty
count  out  AW+1  current number of stored frames
empty  out  1  high when count == 0
full  out  1  high when count == DEPTH
err_ovf  out  1  sticky; set by a push while full
err_udf  out  1  sticky; set by a pop while empty

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - sp = 0; count = 0.
  - readySig, pop_empty, err_ovf and err_udf = 0.
  - n_out, flag_out and res_out = 0.
  - RAM contents are not cleared.
  - Reset mid-operation abandons the request with no readySig; the requester must re-request.
- FSM states: IDLE, PUSH, POPRD, POPCAP, ACK.
- IDLE:
  - pushSig=1 -> PUSH. pushSig has priority when pushSig and popSig are both high; the pop stays pending.
  - pushSig=0 and popSig=1 -> POPRD.
  - Otherwise stay in IDLE.
- PUSH (if not full):
  - Write {res_in, flag_in, n_in} to address sp; sp++.
  - Inputs are sampled in this cycle.
  - Go to ACK.
- PUSH (if full):
  - No write; sp unchanged; set err_ovf.
  - Go to ACK.
- POPRD (if not empty):
  - Present read address sp-1 to the RAM.
  - Go to POPCAP.
- POPRD (if empty):
  - Set err_udf; set the pop_empty register.
  - Outputs unchanged.
  - Go directly to ACK.
- POPCAP:
  - RAM data is valid; capture it into n_out, flag_out and res_out; sp--.
  - Go to ACK.
- ACK:
  - readySig = 1 for exactly this cycle.
  - pop_empty is valid only in this cycle; otherwise 0.
  - Requests are ignored; always go to IDLE.
  - This state guarantees a held request is not accepted twice.
- Latency, measured from the first cycle a request is seen in IDLE:
  - Push: readySig high 2 cycles later.
  - Pop, not empty: readySig high 3 cycles later.
  - Pop, empty: readySig high 2 cycles later.
- Popped data are valid in the readySig cycle and stay stable afterwards.
- count equals sp; empty and full are derived combinationally from sp.
- Wrap-around is never permitted: sp saturates in 0..DEPTH.
- err_ovf and err_udf are cleared only by rst.

Optional Feature:
FRAME_STACK_HWM_EN
- When defined:
  - Adds output hwm [AW+1 bits], the high-water mark of count since reset.
  - Updated the cycle after count rises above it; reset to 0.
- When undefined:
  - hwm port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package frame_stack_pkg holds:
  - the FSM state enumeration (3-bit encoding);
  - frame field width constant (8) and frame width constant (3*8);
  - field bit positions within the packed frame (n [7:0], flag [15:8], res [23:16]).
- One sub-module, frame_stack_ram:
  - single-port DEPTH x 3*DW RAM;
  - synchronous write, registered (one-cycle) read.

Test Plan:
- Reset, then push n=5, flag=0, res=0 -> readySig exactly 2 cycles later; count=1; empty=0.
- Push (5,0,0), push (4,1,3), then pop -> readySig 3 cycles after the pop is seen; outputs n=4, flag=1, res=3; count=1. Pop again -> n=5, flag=0, res=0; empty=1.
- Pop on empty stack -> readySig 2 cycles later with pop_empty=1; err_udf=1; outputs unchanged; count=0.
- Fill all 16 slots, then push (9,9,9) -> readySig pulses; err_ovf=1; count=16. The following pop returns the 16th frame, not (9,9,9).
- Assert pushSig and popSig together with the stack empty, both held -> push is serviced first (count=1), then the pop returns the pushed frame. Exactly 2 readySig pulses, each 1 cycle wide.
- Assert rst in the POPCAP cycle -> no readySig; count=0; err flags=0; a later push/pop returns the newly pushed data.

Source files
------------

// File: rtl/frame_stack_pkg.sv
// Frame stack shared types: FSM encoding, frame widths, field positions.
// Frame layout is {res, flag, n} with n in the low byte.
package frame_stack_pkg;
  localparam int FIELD_W  = 8;
  localparam int FRAME_W  = 3 * FIELD_W;
  localparam int N_LSB    = 0;
  localparam int FLAG_LSB = 8;
  localparam int RES_LSB  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POPRD,
    ST_POPCAP,
    ST_ACK
  } state_e;
endpackage

// File: rtl/frame_stack_if.sv
// Request/response bundle between recursion controller and frame stack.
// master: requester side; slave: frame_stack_ctrl. FRAME_STACK_HWM_EN adds hwm.
interface frame_stack_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          pushSig;
  logic          popSig;
  logic [DW-1:0] n_in;
  logic [DW-1:0] flag_in;
  logic [DW-1:0] res_in;
  logic          readySig;
  logic [DW-1:0] n_out;
  logic [DW-1:0] flag_out;
  logic [DW-1:0] res_out;
  logic          pop_empty;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          err_ovf;
  logic          err_udf;
`ifdef FRAME_STACK_HWM_EN
  logic [AW:0]   hwm;

  modport master (
    output pushSig, popSig, n_in, flag_in, res_in,
    input  readySig, n_out, flag_out, res_out, pop_empty,
    input  count, empty, full, err_ovf, err_udf, hwm
  );
  modport slave (
    input  pushSig, popSig, n_in, flag_in, res_in,
    output readySig, n_out, flag_out, res_out, pop_empty,
    output count, empty, full, err_ovf, err_udf, hwm
  );
`else
  modport master (
    output pushSig, popSig, n_in, flag_in, res_in,
    input  readySig, n_out, flag_out, res_out, pop_empty,
    input  count, empty, full, err_ovf, err_udf
  );
  modport slave (
    input  pushSig, popSig, n_in, flag_in, res_in,
    output readySig, n_out, flag_out, res_out, pop_empty,
    output count, empty, full, err_ovf, err_udf
  );
`endif
endinterface

// File: rtl/frame_stack_ram.sv
// Single-port DEPTH x W frame RAM, synchronous write, one-cycle registered read.
// Ports: clk, we_i, addr_i, wdata_i, rdata_o. Contents are never reset.
module frame_stack_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_stack_ctrl.sv
// Frame stack controller: push/pop FSM over frame_stack_ram, readySig pulse per request.
// Ports: clk, rst (sync, active high), bus (frame_stack_if.slave). FRAME_STACK_HWM_EN adds hwm.
module frame_stack_ctrl
  import frame_stack_pkg::*;
#(
  parameter int DW    = FIELD_W,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  frame_stack_if.slave bus
);
  state_e          state_q, state_d;
  logic [AW:0]     sp_q, sp_d;
  logic [DW-1:0]   n_q, flag_q, res_q;
  logic            pe_q, pe_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            cap;
  logic            we;
  logic [AW-1:0]   addr;
  logic            full, empty;
  logic [3*DW-1:0] wdata, rdata;

  assign full  = (sp_q == (AW+1)'(DEPTH));
  assign empty = (sp_q == '0);
  assign wdata = {bus.res_in, bus.flag_in, bus.n_in};

  frame_stack_ram #(
    .W     (3*DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    pe_d    = 1'b0;
    cap     = 1'b0;
    we      = 1'b0;
    addr    = sp_q[AW-1:0];
    unique case (state_q)
      ST_IDLE: begin
        if (bus.pushSig)     state_d = ST_PUSH;
        else if (bus.popSig) state_d = ST_POPRD;
      end
      ST_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
        end
        state_d = ST_ACK;
      end
      ST_POPRD: begin
        if (empty) begin
          udf_d   = 1'b1;
          pe_d    = 1'b1;
          state_d = ST_ACK;
        end else begin
          // At sp == DEPTH the low bits are 0, so this still lands on DEPTH-1.
          addr    = sp_q[AW-1:0] - 1'b1;
          state_d = ST_POPCAP;
        end
      end
      ST_POPCAP: begin
        cap     = 1'b1;
        sp_d    = sp_q - 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      pe_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      n_q     <= '0;
      flag_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pe_q    <= pe_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      if (cap) begin
        n_q    <= rdata[N_LSB +: DW];
        flag_q <= rdata[FLAG_LSB +: DW];
        res_q  <= rdata[RES_LSB +: DW];
      end
    end
  end

`ifdef FRAME_STACK_HWM_EN
  logic [AW:0] hwm_q;

  always_ff @(posedge clk) begin
    if (rst)              hwm_q <= '0;
    else if (sp_q > hwm_q) hwm_q <= sp_q;
  end

  assign bus.hwm = hwm_q;
`endif

  // pe_q is only ever set on the POPRD->ACK edge, so it is high in ACK alone.
  assign bus.readySig  = (state_q == ST_ACK);
  assign bus.pop_empty = pe_q;
  assign bus.n_out     = n_q;
  assign bus.flag_out  = flag_q;
  assign bus.res_out   = res_q;
  assign bus.count     = sp_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_udf   = udf_q;
endmodule
